irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/trsq8_pkg.sv | 20 ++
 rtl/irq_sync_edge.sv | 27 ++
 rtl/irq_controller.sv | 147 ++++++++++++++
 tb/tb_irq_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/trsq8_pkg.sv
// Shared register map and FSM encodings for the interrupt controller.
package trsq8_pkg;

  localparam logic [2:0] OFS_PEND   = 3'd0;
  localparam logic [2:0] OFS_MASK   = 3'd1;
  localparam logic [2:0] OFS_VECTOR = 3'd2;
  localparam logic [2:0] OFS_EDGE   = 3'd3;
  localparam logic [2:0] OFS_EOI    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  function automatic logic [7:0] vec_code(input logic [2:0] idx);
    return {1'b1, 4'b0000, idx};
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: 2-flop synchronizer followed by a rising-edge detector.
module irq_sync_edge (
  input  logic clk_ip,
  input  logic reset,
  input  logic src_ip,
  output logic lvl_op,
  output logic rise_op
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_ip) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= src_ip;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_op  = s2_q;
  assign rise_op = s2_q & ~s3_q;

endmodule

// File: rtl/irq_controller.sv
// Non-nesting interrupt controller: pending/mask/edge registers, fixed
// lowest-index priority and an IDLE/REQ/SERVICE handshake with the CPU.
module irq_controller
  import trsq8_pkg::*;
#(
  parameter int         NSRC = 8,
  parameter logic [7:0] BASE = 8'h10
) (
  input  logic            clk_ip,
  input  logic            reset,
  input  logic [NSRC-1:0] src_ip,
  input  logic [7:0]      addr_ip,
  input  logic [7:0]      data_ip,
  input  logic            wr_en_ip,
  input  logic            rd_en_ip,
  output logic [7:0]      data_op,
  output logic            irq_op
);

  logic [NSRC-1:0] lvl, rise;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .clk_ip  (clk_ip),
      .reset   (reset),
      .src_ip  (src_ip[g]),
      .lvl_op  (lvl[g]),
      .rise_op (rise[g])
    );
  end

  logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, edge_q, edge_d;
  logic [2:0]      insvc_q, insvc_d;
  irq_state_e      state_q, state_d;
  logic            irq_q;

  // Offset wraps for addresses below BASE, so one compare bounds the window.
  logic [7:0] ofs8;
  logic [2:0] ofs;
  logic       hit;
  assign ofs8 = addr_ip - BASE;
  assign hit  = (ofs8 < 8'd5);
  assign ofs  = ofs8[2:0];

  logic wr_pend, wr_mask, wr_edge, wr_eoi, rd_vec;
  assign wr_pend = wr_en_ip & hit & (ofs == OFS_PEND);
  assign wr_mask = wr_en_ip & hit & (ofs == OFS_MASK);
  assign wr_edge = wr_en_ip & hit & (ofs == OFS_EDGE);
  assign wr_eoi  = wr_en_ip & hit & (ofs == OFS_EOI);
  assign rd_vec  = rd_en_ip & hit & (ofs == OFS_VECTOR);

  logic [NSRC-1:0] pm;
  logic            found;
  logic [2:0]      idx;
  logic [7:0]      vector;

  always_comb begin
    pm    = pend_q & mask_q;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (pm[i]) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
    vector = found ? vec_code(idx) : 8'h00;
  end

  logic grant;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE:    if (found) state_d = ST_REQ;
      ST_REQ: begin
        if (rd_vec && found) begin
          state_d = ST_SERVICE;
          grant   = 1'b1;
        end else if (!found) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: if (wr_eoi) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  logic [NSRC-1:0] set_v, clr_v;

  // A set event in the same cycle as a clear wins, so no edge is lost.
  always_comb begin
    insvc_d = insvc_q;
    if (grant) insvc_d = idx;
    set_v = (edge_q & rise) | (~edge_q & lvl);
    clr_v = wr_pend ? data_ip[NSRC-1:0] : '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant && (insvc_d == 3'(i)) && edge_q[i]) clr_v[i] = 1'b1;
    end
    pend_d = (pend_q & ~clr_v) | set_v;
    mask_d = wr_mask ? data_ip[NSRC-1:0] : mask_q;
    edge_d = wr_edge ? data_ip[NSRC-1:0] : edge_q;
  end

  always_ff @(posedge clk_ip) begin
    if (reset) begin
      pend_q  <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      insvc_q <= 3'd0;
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      insvc_q <= insvc_d;
      state_q <= state_d;
      irq_q   <= (state_d == ST_REQ);
    end
  end

  assign irq_op = irq_q;

  logic [7:0] pend8, mask8, edge8;

  always_comb begin
    pend8 = 8'h00;
    mask8 = 8'h00;
    edge8 = 8'h00;
    pend8[NSRC-1:0] = pend_q;
    mask8[NSRC-1:0] = mask_q;
    edge8[NSRC-1:0] = edge_q;
    data_op = 8'h00;
    if (rd_en_ip && hit) begin
      case (ofs)
        OFS_PEND:   data_op = pend8;
        OFS_MASK:   data_op = mask8;
        OFS_VECTOR: data_op = vector;
        OFS_EDGE:   data_op = edge8;
        default:    data_op = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios plus random traffic against a rule-level model.
module tb_irq_controller;

  localparam logic [7:0] BASE = 8'h10;
  localparam logic [7:0] NONE = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] src = 8'h00, addr = 8'h00, data = 8'h00;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] data_o;
  logic       irq;

  irq_controller #(.NSRC(8), .BASE(BASE)) dut (
    .clk_ip   (clk),
    .reset    (reset),
    .src_ip   (src),
    .addr_ip  (addr),
    .data_ip  (data),
    .wr_en_ip (wr_en),
    .rd_en_ip (rd_en),
    .data_op  (data_o),
    .irq_op   (irq)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Model: samples[0] newest src sample; mode 0 idle, 1 request, 2 service.
  logic [7:0] samples [3];
  logic [7:0] m_pend = 0, m_mask = 0, m_edge = 0;
  int         m_mode = 0;
  logic [7:0] last_rd;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_vec();
    logic [7:0] pm = m_pend & m_mask;
    for (int i = 0; i < 8; i++) if (pm[i]) return 8'h80 + 8'(i);
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a < BASE || a > BASE + 8'd4) return 8'h00;
    case (a - BASE)
      8'd0:    return m_pend;
      8'd1:    return m_mask;
      8'd2:    return m_vec();
      8'd3:    return m_edge;
      default: return 8'h00;
    endcase
  endfunction

  task automatic cyc(input logic [7:0] s, input logic [7:0] a, input logic [7:0] d,
                     input logic w, input logic r, input logic rs);
    logic [7:0] lvl, rise, setv, clrv, vec;
    logic       grant;
    int         gi;
    src = s; addr = a; data = d; wr_en = w; rd_en = r; reset = rs;
    #1;
    last_rd = data_o;
    if (r) chk("read", data_o, m_read(a));
    lvl  = samples[1];
    rise = samples[1] & ~samples[2];
    vec  = m_vec();
    gi   = int'(vec[2:0]);
    grant = (m_mode == 1) && r && (a == BASE + 8'd2) && (vec != 0);
    setv = 0;
    for (int i = 0; i < 8; i++) setv[i] = m_edge[i] ? rise[i] : lvl[i];
    clrv = (w && a == BASE) ? d : 8'h00;
    if (grant && m_edge[gi]) clrv[gi] = 1'b1;
    @(posedge clk);
    #1;
    if (rs) begin
      m_pend = 0; m_mask = 0; m_edge = 0; m_mode = 0;
      samples[0] = 0; samples[1] = 0; samples[2] = 0;
    end else begin
      case (m_mode)
        0: if (vec != 0) m_mode = 1;
        1: if (grant) m_mode = 2; else if (vec == 0) m_mode = 0;
        default: if (w && a == BASE + 8'd4) m_mode = 0;
      endcase
      m_pend = (m_pend & ~clrv) | setv;
      if (w && a == BASE + 8'd1) m_mask = d;
      if (w && a == BASE + 8'd3) m_edge = d;
      samples[2] = samples[1];
      samples[1] = samples[0];
      samples[0] = s;
    end
    chk("irq", {7'b0, irq}, {7'b0, m_mode == 1});
  endtask

  task automatic idle(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) cyc(s, NONE, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [7:0] s, input logic [7:0] ofs, input logic [7:0] d);
    cyc(s, BASE + ofs, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] s, input logic [7:0] ofs);
    cyc(s, BASE + ofs, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    samples[0] = 0; samples[1] = 0; samples[2] = 0;
    cyc(8'h00, NONE, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, NONE, 8'h00, 1'b0, 1'b0, 1'b1);
    rd(8'h00, 0); chk("rst_pend", last_rd, 8'h00);
    rd(8'h00, 1); chk("rst_mask", last_rd, 8'h00);
    rd(8'h00, 2); chk("rst_vec", last_rd, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);

    // single edge source
    wr(8'h00, 1, 8'h04);
    wr(8'h00, 3, 8'h04);
    idle(8'h04, 1);
    idle(8'h00, 2);
    rd(8'h00, 0); chk("pend_2", last_rd, 8'h04);
    chk("irq_up", {7'b0, irq}, 8'h01);
    rd(8'h00, 2); chk("vec_82", last_rd, 8'h82);
    chk("irq_svc", {7'b0, irq}, 8'h00);
    wr(8'h00, 4, 8'h00);

    // two simultaneous sources, priority then re-request after EOI
    wr(8'h00, 3, 8'hFF);
    wr(8'h00, 1, 8'hFF);
    idle(8'h22, 1);
    idle(8'h00, 3);
    rd(8'h00, 2); chk("vec_81", last_rd, 8'h81);
    wr(8'h00, 4, 8'h00);
    idle(8'h00, 1);
    chk("irq_re", {7'b0, irq}, 8'h01);
    rd(8'h00, 2); chk("vec_85", last_rd, 8'h85);

    // no nesting: new edge during service waits for EOI
    idle(8'h08, 1);
    idle(8'h00, 4);
    chk("no_nest", {7'b0, irq}, 8'h00);
    wr(8'h00, 4, 8'h00);
    idle(8'h00, 1);
    chk("irq_after_eoi", {7'b0, irq}, 8'h01);
    rd(8'h00, 2); chk("vec_83", last_rd, 8'h83);
    wr(8'h00, 4, 8'h00);

    // level mode survives W1C while the line stays high
    wr(8'h00, 3, 8'h00);
    idle(8'h01, 3);
    wr(8'h01, 0, 8'h01);
    rd(8'h01, 0); chk("lvl_hold", last_rd & 8'h01, 8'h01);
    idle(8'h00, 3);
    wr(8'h00, 0, 8'hFF);
    idle(8'h00, 2);
    chk("req_drop", {7'b0, irq}, 8'h00);

    // set beats coincident W1C
    wr(8'h00, 1, 8'h00);
    wr(8'h00, 3, 8'h04);
    idle(8'h04, 1);
    idle(8'h00, 3);
    idle(8'h04, 1);
    idle(8'h00, 1);
    wr(8'h00, 0, 8'h04);
    rd(8'h00, 0); chk("set_wins", last_rd & 8'h04, 8'h04);

    // reset in service
    wr(8'h00, 1, 8'h04);
    idle(8'h00, 1);
    rd(8'h00, 2); chk("vec_pre_rst", last_rd, 8'h82);
    cyc(8'h00, NONE, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_svc_irq", {7'b0, irq}, 8'h00);
    rd(8'h00, 0); chk("rst_svc_pend", last_rd, 8'h00);
    rd(8'h00, 1); chk("rst_svc_mask", last_rd, 8'h00);
    chk("rst_svc_idle", {7'b0, irq}, 8'h00);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0] s, a, d;
      logic       w, r, rs;
      s = src;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) s[b] = ~s[b];
      a  = ($urandom_range(0, 15) == 0) ? 8'(($urandom)) : BASE - 8'd1 + 8'($urandom_range(0, 6));
      d  = 8'($urandom);
      w  = ($urandom_range(0, 9) < 3);
      r  = ($urandom_range(0, 9) < 5);
      rs = ($urandom_range(0, 199) == 0);
      cyc(s, a, d, w, r, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
